// File: rtl/router_pkt_src_if.sv
// Command, payload and router-side signals of the store-and-forward packet source.
interface router_pkt_src_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_addr;
  logic [5:0]  cmd_len;
  logic        cmd_bad_parity;
  logic        pl_valid;
  logic        pl_ready;
  logic [7:0]  pl_data;
  logic        busy;
  logic [7:0]  data_out;
  logic        pkt_valid;
  logic        pkt_done;
  logic        cmd_err;
  logic [15:0] pkt_count;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, cmd_bad_parity, pl_valid, pl_data, busy,
    input  cmd_ready, pl_ready, data_out, pkt_valid, pkt_done, cmd_err, pkt_count
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, cmd_bad_parity, pl_valid, pl_data, busy,
    output cmd_ready, pl_ready, data_out, pkt_valid, pkt_done, cmd_err, pkt_count
  );
endinterface

// File: rtl/router_pkt_src.sv
// Buffers a whole payload, then replays header/payload/parity to the router at line rate.
// Router busy freezes the presented byte; a fixed idle gap separates packets.
module router_pkt_src #(
  parameter int MAX_LEN    = 63,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clock,
  input  logic             resetn,
  router_pkt_src_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, FILL, WAIT, HDR, PLD, PAR, GAP} state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t      state, state_nx;
  logic [1:0]  addr_q, addr_nx;
  logic [5:0]  len_q, len_nx;
  logic        bad_q, bad_nx;
  logic [7:0]  par_q, par_nx;
  logic [5:0]  wr_ptr, wr_ptr_nx;
  logic [5:0]  rd_ptr, rd_ptr_nx;
  logic [3:0]  gap_cnt, gap_cnt_nx;
  logic [7:0]  dout_q, dout_nx;
  logic        vld_q, vld_nx;
  logic        done_q, done_nx;
  logic        err_q, err_nx;
  logic [15:0] cnt_q, cnt_nx;
  logic        wr_en;
  logic        cmd_hs, pl_hs;
  logic [7:0]  mem [MAX_LEN];

  assign cmd_hs = bus.cmd_valid & (state == IDLE);
  assign pl_hs  = bus.pl_valid & (state == FILL);

  always_comb begin
    state_nx   = state;
    addr_nx    = addr_q;
    len_nx     = len_q;
    bad_nx     = bad_q;
    par_nx     = par_q;
    wr_ptr_nx  = wr_ptr;
    rd_ptr_nx  = rd_ptr;
    gap_cnt_nx = gap_cnt;
    dout_nx    = dout_q;
    vld_nx     = vld_q;
    cnt_nx     = cnt_q;
    done_nx    = 1'b0;
    err_nx     = 1'b0;
    wr_en      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_hs) begin
          addr_nx = bus.cmd_addr;
          len_nx  = bus.cmd_len;
          bad_nx  = bus.cmd_bad_parity;
          if (bus.cmd_addr == 2'd3 || bus.cmd_len == 6'd0) begin
            err_nx = 1'b1;
          end else begin
            par_nx    = {bus.cmd_len, bus.cmd_addr};
            wr_ptr_nx = 6'd0;
            rd_ptr_nx = 6'd0;
            state_nx  = FILL;
          end
        end
      end
      FILL: begin
        if (pl_hs) begin
          wr_en     = 1'b1;
          par_nx    = par_q ^ bus.pl_data;
          wr_ptr_nx = wr_ptr + 6'd1;
          if (wr_ptr == len_q - 6'd1) state_nx = WAIT;
        end
      end
      WAIT: begin
        if (!bus.busy) begin
          dout_nx  = {len_q, addr_q};
          vld_nx   = 1'b1;
          state_nx = HDR;
        end
      end
      HDR: begin
        if (!bus.busy) begin
          dout_nx   = mem[0];
          rd_ptr_nx = 6'd1;
          state_nx  = PLD;
        end
      end
      PLD: begin
        // rd_ptr is the index of the next byte to load; reaching len means the last one is on the wire
        if (!bus.busy) begin
          if (rd_ptr == len_q) begin
            dout_nx  = par_q ^ {8{bad_q}};
            vld_nx   = 1'b0;
            state_nx = PAR;
          end else begin
            dout_nx   = mem[rd_ptr];
            rd_ptr_nx = rd_ptr + 6'd1;
          end
        end
      end
      PAR: begin
        if (!bus.busy) begin
          dout_nx    = 8'd0;
          done_nx    = 1'b1;
          cnt_nx     = cnt_q + 16'd1;
          gap_cnt_nx = 4'd0;
          state_nx   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nx = IDLE;
        else                     gap_cnt_nx = gap_cnt + 4'd1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      addr_q  <= 2'd0;
      len_q   <= 6'd0;
      bad_q   <= 1'b0;
      par_q   <= 8'd0;
      wr_ptr  <= 6'd0;
      rd_ptr  <= 6'd0;
      gap_cnt <= 4'd0;
      dout_q  <= 8'd0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state   <= state_nx;
      addr_q  <= addr_nx;
      len_q   <= len_nx;
      bad_q   <= bad_nx;
      par_q   <= par_nx;
      wr_ptr  <= wr_ptr_nx;
      rd_ptr  <= rd_ptr_nx;
      gap_cnt <= gap_cnt_nx;
      dout_q  <= dout_nx;
      vld_q   <= vld_nx;
      done_q  <= done_nx;
      err_q   <= err_nx;
      cnt_q   <= cnt_nx;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= bus.pl_data;
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.pl_ready  = (state == FILL);
  assign bus.data_out  = dout_q;
  assign bus.pkt_valid = vld_q;
  assign bus.pkt_done  = done_q;
  assign bus.cmd_err   = err_q;
  assign bus.pkt_count = cnt_q;
endmodule

// File: tb/tb_router_pkt_src.sv
// Directed and randomized packets checked against a byte-queue model of the wire.
module tb_router_pkt_src;
  localparam int MAX_LEN    = 63;
  localparam int GAP_CYCLES = 2;

  logic clock  = 1'b0;
  logic resetn = 1'b1;
  always #5 clock = ~clock;

  router_pkt_src_if bus();

  router_pkt_src #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  int          n_cmp;
  int          n_err;
  logic [15:0] exp_count;
  logic [7:0]  pl_arr [64];
  logic [7:0]  last_hdr;
  logic [7:0]  last_par;
  int          last_pres;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // mode 0: never busy, 1: random busy, 2: busy for 3 cycles while byte index 3 is shown
  task automatic run_pkt(input logic [1:0] a, input logic [5:0] l, input logic bad,
                         input int mode, input int abort_at);
    logic [7:0] exp_q[$];
    logic [7:0] par;
    int         n, pos, cyc, acc, pres, busy_cycles, bcnt, g;
    bit         started, hs, b;
    exp_q = {};
    exp_q.push_back({l, a});
    for (int i = 0; i < int'(l); i++) exp_q.push_back(pl_arr[i]);
    par = 8'd0;
    foreach (exp_q[i]) par = par ^ exp_q[i];
    exp_q.push_back(bad ? ~par : par);
    n = int'(l) + 2;

    cyc = 0;
    while (bus.cmd_ready !== 1'b1 && cyc < 200) begin
      @(posedge clock); #1; cyc++;
    end
    chk("cmd_ready_idle", 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1; bus.cmd_addr = a; bus.cmd_len = l; bus.cmd_bad_parity = bad;
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0; bus.cmd_bad_parity = 1'($urandom);
    chk("pl_ready_fill", 32'(bus.pl_ready), 1);
    chk("cmd_ready_fill", 32'(bus.cmd_ready), 0);

    acc = 0; cyc = 0;
    while (acc < int'(l) && cyc < 1000) begin
      bus.pl_valid  = ($urandom_range(0, 3) != 0);
      bus.pl_data   = bus.pl_valid ? pl_arr[acc] : 8'($urandom);
      bus.cmd_valid = 1'($urandom);
      bus.cmd_addr  = 2'd3; bus.cmd_len = 6'd0;
      hs = bus.pl_valid && bus.pl_ready;
      @(posedge clock); #1; cyc++;
      if (hs) acc++;
      chk("cmd_err_fill", 32'(bus.cmd_err), 0);
    end
    bus.pl_valid = 1'b0; bus.cmd_valid = 1'b0;
    chk("payload_accepted", 32'(acc), 32'(l));
    chk("pl_ready_after_fill", 32'(bus.pl_ready), 0);

    started = 0; pos = 0; cyc = 0; pres = 0; busy_cycles = 0; bcnt = 0;
    while (pos < n && cyc < 2000) begin
      if (!started && bus.pkt_valid === 1'b1) started = 1;
      if (started) begin
        chk("wire_byte", 32'(bus.data_out), 32'(exp_q[pos]));
        chk("pkt_valid", 32'(bus.pkt_valid), 32'(pos < n - 1));
        if (pos == 0) last_hdr = bus.data_out;
        if (pos == n - 1) last_par = bus.data_out;
        if (pos == abort_at) begin
          resetn = 1'b0; #1;
          chk("abort_data_out", 32'(bus.data_out), 0);
          chk("abort_pkt_valid", 32'(bus.pkt_valid), 0);
          chk("abort_cmd_ready", 32'(bus.cmd_ready), 1);
          chk("abort_pkt_done", 32'(bus.pkt_done), 0);
          chk("abort_pkt_count", 32'(bus.pkt_count), 0);
          resetn = 1'b1; bus.busy = 1'b0; exp_count = 16'd0;
          return;
        end
        pres++;
      end
      case (mode)
        1:       b = ($urandom_range(0, 2) == 0);
        2:       b = started && pos == 3 && bcnt < 3;
        default: b = 0;
      endcase
      if (mode == 2 && b) bcnt++;
      if (started && b) busy_cycles++;
      bus.busy = b;
      @(posedge clock); #1; cyc++;
      if (started && !b) pos++;
    end
    last_pres = pres;
    exp_count = exp_count + 16'd1;
    chk("pkt_done", 32'(bus.pkt_done), 1);
    chk("data_out_after_par", 32'(bus.data_out), 0);
    chk("pkt_count", 32'(bus.pkt_count), 32'(exp_count));
    chk("present_cycles", 32'(pres), 32'(n + busy_cycles));

    g = 0;
    while (bus.cmd_ready !== 1'b1 && g < 50) begin
      chk("gap_quiet", 32'({bus.pkt_valid, bus.data_out}), 0);
      bus.busy = 1'($urandom);
      @(posedge clock); #1; g++;
      chk("pkt_done_once", 32'(bus.pkt_done), 0);
    end
    bus.busy = 1'b0;
    chk("gap_len", 32'(g), GAP_CYCLES);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; exp_count = 16'd0;
    bus.cmd_valid = 1'b0; bus.cmd_addr = 2'd0; bus.cmd_len = 6'd0; bus.cmd_bad_parity = 1'b0;
    bus.pl_valid = 1'b0; bus.pl_data = 8'd0; bus.busy = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_pl_ready", 32'(bus.pl_ready), 0);
    chk("rst_data_out", 32'(bus.data_out), 0);
    chk("rst_pkt_valid", 32'(bus.pkt_valid), 0);
    chk("rst_pkt_done", 32'(bus.pkt_done), 0);
    chk("rst_cmd_err", 32'(bus.cmd_err), 0);
    chk("rst_pkt_count", 32'(bus.pkt_count), 0);
    #10 resetn = 1'b1;
    @(posedge clock); #1;

    pl_arr[0] = 8'hA1; pl_arr[1] = 8'hB2; pl_arr[2] = 8'hC3; pl_arr[3] = 8'hD4; pl_arr[4] = 8'hE5;
    run_pkt(2'd2, 6'd5, 1'b0, 0, 3);
    run_pkt(2'd2, 6'd5, 1'b0, 0, -1);
    chk("hdr_0x16", 32'(last_hdr), 32'h16);
    chk("par_0xF7", 32'(last_par), 32'hF7);
    chk("count_1", 32'(bus.pkt_count), 1);
    run_pkt(2'd2, 6'd5, 1'b1, 0, -1);
    chk("bad_par_0x08", 32'(last_par), 32'h08);
    run_pkt(2'd2, 6'd5, 1'b0, 2, -1);
    chk("busy_pres_10", 32'(last_pres), 10);

    bus.cmd_valid = 1'b1; bus.cmd_addr = 2'd3; bus.cmd_len = 6'd4; bus.pl_valid = 1'b1;
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    chk("err1_pulse", 32'(bus.cmd_err), 1);
    chk("err1_pl_ready", 32'(bus.pl_ready), 0);
    chk("err1_cmd_ready", 32'(bus.cmd_ready), 1);
    @(posedge clock); #1;
    chk("err1_end", 32'(bus.cmd_err), 0);
    bus.cmd_valid = 1'b1; bus.cmd_addr = 2'd1; bus.cmd_len = 6'd0;
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    chk("err2_pulse", 32'(bus.cmd_err), 1);
    chk("err2_pl_ready", 32'(bus.pl_ready), 0);
    @(posedge clock); #1;
    bus.pl_valid = 1'b0;
    chk("err2_end", 32'(bus.cmd_err), 0);
    chk("err_no_pkt_valid", 32'(bus.pkt_valid), 0);
    chk("err_count_same", 32'(bus.pkt_count), 32'(exp_count));

    for (int i = 0; i < 63; i++) pl_arr[i] = 8'hFF;
    run_pkt(2'd1, 6'd63, 1'b0, 0, -1);
    chk("max_hdr_0xFD", 32'(last_hdr), 32'hFD);
    chk("max_par_0x02", 32'(last_par), 32'h02);
    chk("max_pres_65", 32'(last_pres), 65);

    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 64; i++) pl_arr[i] = 8'($urandom);
      run_pkt(2'($urandom_range(0, 2)), 6'($urandom_range(1, MAX_LEN)), 1'($urandom), 1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/router_pkt_src.md
Name: router_pkt_src

Overview:
- Store-and-forward packet source. Drives the router input side (data_in / pkt_valid / busy) with complete packets: header, payload, parity.
- Accepts a command (destination address, payload length), buffers the payload from a byte stream, generates the header and parity, and replays the packet at line rate while honouring router busy.
- Used as the upstream transmitter for the router in system tests and in the integration bench.

Parameters:
- MAX_LEN, 63, maximum payload bytes; also the depth of the internal payload buffer (6-bit length field).
- GAP_CYCLES, 2, idle cycles after each packet with pkt_valid=0 and data_out=0 (range 1..15).

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- resetn  input  1  asynchronous active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at a rising edge
- cmd_addr  input  2  destination port 0..2; 3 is illegal
- cmd_len  input  6  payload length 1..63; 0 is illegal
- cmd_bad_parity  input  1  inject error: send the bitwise inverse of the correct parity
- pl_valid  input  1  payload byte valid
- pl_ready  output  1  payload byte accepted when pl_valid & pl_ready at a rising edge
- pl_data  input  8  payload byte
- busy  input  1  router busy; the presented byte is not consumed while busy=1
- data_out  output  8  byte to the router data_in
- pkt_valid  output  1  high for header and payload bytes, low for the parity byte
- pkt_done  output  1  one-cycle pulse when the parity byte is consumed
- cmd_err  output  1  one-cycle pulse when an illegal command is dropped
- pkt_count  output  16  number of packets completed; wraps at 0xFFFF->0

Behaviour:
- Reset: all outputs 0 except cmd_ready=1. State=IDLE, parity, counters and buffer pointers cleared. Takes effect immediately (asynchronous).
- Reset mid-packet aborts the packet: data_out=0, pkt_valid=0 at once, no pkt_done.
- States: IDLE, FILL, WAIT, HDR, PLD, PAR, GAP.
- IDLE:
  - cmd_ready=1; pl_ready=0.
  - On command handshake, latch addr, len and bad_parity flag.
  - Illegal command (addr==3 or len==0): pulse cmd_err next cycle, stay in IDLE, consume no payload.
  - Legal command: header={len,addr}, parity<=header, go to FILL.
- FILL:
  - pl_ready=1; cmd_ready=0.
  - Each pl handshake writes buf[wr_ptr], parity^=pl_data, wr_ptr++.
  - After the len-th byte, go to WAIT.
- WAIT: pl_ready=0. On the first edge with busy=0, register data_out=header and pkt_valid=1, then go to HDR.
- Presentation rule (HDR/PLD/PAR):
  - The byte on data_out is consumed at each rising edge where busy=0.
  - While busy=1, data_out and pkt_valid hold unchanged and nothing advances.
- HDR, when consumed: data_out<=buf[0], go to PLD.
- PLD, when consumed:
  - If not the last byte: data_out<=next buf entry.
  - On the last byte: data_out<=parity (inverted if bad_parity), pkt_valid<=0, go to PAR.
- PAR, when consumed: data_out<=0, pulse pkt_done, pkt_count++, go to GAP.
- GAP: hold GAP_CYCLES cycles, then go to IDLE.
- Parity = XOR of header and all payload bytes, 8-bit.
- Minimum packet: 1 edge in WAIT plus len+2 presentation cycles. Byte order on the wire is exactly the pl order.
- busy rising while in WAIT delays the header. busy is not sampled in IDLE, FILL or GAP.
- pl_valid outside FILL is ignored. cmd_valid outside IDLE is ignored (no handshake).

Test Plan:
- Reset mid-PLD with busy=0 → data_out=0x00, pkt_valid=0, cmd_ready=1 immediately; next legal command sends a fresh header.
- cmd addr=2, len=5, payload A1 B2 C3 D4 E5, busy=0 → wire sequence 0x16, A1, B2, C3, D4, E5 with pkt_valid=1, then 0xF7 with pkt_valid=0; pkt_done pulse; pkt_count=1.
- Same packet with cmd_bad_parity=1 → parity byte 0x08; all other bytes unchanged.
- Same packet, busy=1 for 3 cycles while 0xC3 is presented → 0xC3 held for 4 cycles, no byte skipped or duplicated after busy falls, total presentation 10 cycles.
- cmd addr=3 len=4, then cmd len=0 → two cmd_err pulses, pl_ready stays 0, no pkt_valid activity.
- len=63 packet, all payload 0xFF, addr=1 → header 0xFD, parity 0xFD^0xFF=0x02, exactly 65 presented bytes, GAP_CYCLES idle cycles before cmd_ready=1.
